mr_busarb: RTL and testbench
============================

# mr_busarb

Two-master Wishbone (pipelined) bus arbiter that shares the single memory port between the instruction fetch unit (I port) and the load/store unit (D port). It holds a grant for the full duration of a master's bus cycle (`cyc`), muxes the granted master's request onto the slave port, and routes responses back only to the granted master. It sits between the core's fetch/LSU stages and the memory/interconnect.

## Interface
Parameters: none; widths come from `` `XLEN `` and `` `XLEN_GRAN `` in `rtl/config.svi`.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_adr_i  in  `XLEN-XLEN_GRAN`  fetch word address
- i_cyc_i, i_stb_i  in  1  fetch cycle / strobe
- i_dat_o  out  `XLEN`  read data to fetch
- i_ack_o, i_err_o, i_stall_o  out  1  fetch responses
- d_adr_i  in  `XLEN-XLEN_GRAN`  LSU word address
- d_dat_i  in  `XLEN`  LSU write data
- d_sel_i  in  `XLEN/8`  LSU byte selects
- d_we_i, d_cyc_i, d_stb_i  in  1  LSU write-enable / cycle / strobe
- d_dat_o  out  `XLEN`  read data to LSU
- d_ack_o, d_err_o, d_stall_o  out  1  LSU responses
- adr_o  out  `XLEN-XLEN_GRAN`  slave address
- dat_o  out  `XLEN`  slave write data
- sel_o  out  `XLEN/8`  slave byte selects
- we_o, cyc_o, stb_o  out  1  slave control
- dat_i  in  `XLEN`  slave read data
- ack_i, err_i, stall_i  in  1  slave responses

## Operation
- States: IDLE, GNT_I, GNT_D. A last-grant flag records the most recently granted master.
- IDLE: samples `i_cyc_i` and `d_cyc_i`. Exactly one high: grant it. Both high: grant per the Configuration policy. Neither high: stay in IDLE.
- GNT_x: the grant is held while `x_cyc_i` is 1.
  - On the edge where `x_cyc_i` is 0, re-arbitrate using the same rules as IDLE.
  - Handoff to the other master is therefore direct, with no idle cycle.
- Slave port = granted master's signals:
  - `cyc_o = x_cyc_i`, `stb_o = x_stb_i`, and `adr_o` from the granted master.
  - I grant: `we_o = 0`, `sel_o` = all ones, `dat_o` = 0.
  - D grant: `we_o`, `sel_o` and `dat_o` pass through from the D port.
  - In IDLE: `cyc_o = stb_o = we_o = 0`.
- Responses:
  - `ack_i`, `err_i` and `stall_i` go only to the granted master.
  - The non-granted master sees `ack = err = 0` and `stall = 1`.
  - `dat_i` is broadcast to both `i_dat_o` and `d_dat_o`.
- A master must not drop `cyc` with acks still outstanding. Violating this is undefined; the arbiter does not count outstanding transfers.
- `err_i` is forwarded like `ack_i` and does not change arbiter state.
- Reset (async, any time, including mid-cycle):
  - State goes to IDLE and last-grant to D.
  - `cyc_o`, `stb_o`, `we_o`, `i_ack_o`, `i_err_o`, `d_ack_o`, `d_err_o` = 0.
  - `i_stall_o` = `d_stall_o` = 1.
  - An in-flight slave cycle is abandoned; the slave must also be reset.

## Timing
- Grant latency: request `cyc` high at cycle N in IDLE → grant registered at edge N+1 → `cyc_o`/`stb_o` visible during cycle N+1.
- Slave outputs and master responses are combinational from the grant state (zero added latency once granted).
- Handoff: granted `cyc` low in cycle N, other master's `cyc` high → other master owns the bus in cycle N+1.
- Back-to-back requests from the same master with `cyc` low for only one cycle are re-arbitrated each time.
- Simultaneous request and release on the same edge are resolved by the policy; no cycle is lost.

## Configuration
- `MR_BUSARB_RR_EN` defined: round-robin. On contention, grant goes to the master that is not the last-grant master.
- Undefined: fixed priority, D always wins contention. The I port may starve while the LSU holds `cyc`; this is accepted.
- Last-grant is tracked in both builds and updated on every grant.

## Test plan
- Single I request: `i_cyc_i`/`i_stb_i` high with `i_adr_i = 0x40`, slave `stall_i = 0`, `ack_i` on cycle 3 with `dat_i = 0x00000013` → `adr_o = 0x40`, `we_o = 0`, `sel_o` all ones from cycle 1; `i_ack_o = 1` and `i_dat_o = 0x13` in cycle 3; `d_ack_o` stays 0.
- Contention, fixed priority: both `cyc` high from IDLE → GNT_D. `i_stall_o = 1` throughout the D cycle. I is granted on the edge after `d_cyc_i` falls.
- Contention with `MR_BUSARB_RR_EN`: last-grant D, both request → I wins. On the next contention → D wins.
- D write: `d_we_i = 1`, `d_sel_i = 0b0011`, `d_dat_i = 0xDEADBEEF` → passed through unchanged. Slave `stall_i = 1` for 2 cycles is reflected on `d_stall_o` only.
- Error: `err_i = 1` during GNT_I → `i_err_o = 1`, `d_err_o = 0`, state stays GNT_I until `i_cyc_i` drops.
- Async reset asserted mid-GNT_D (between clock edges) → `cyc_o`/`stb_o` drop immediately and both stalls = 1. After release, an I request is granted first on contention (last-grant = D).

Source files
------------

// File: rtl/mr_busarb.sv
// Two-master pipelined Wishbone arbiter: I (fetch) and D (LSU) share one slave port.
// Define MR_BUSARB_RR_EN for round-robin contention; default is fixed priority with D winning.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

module mr_busarb (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [`XLEN-`XLEN_GRAN-1:0]   i_adr_i,
    input  logic                          i_cyc_i,
    input  logic                          i_stb_i,
    output logic [`XLEN-1:0]              i_dat_o,
    output logic                          i_ack_o,
    output logic                          i_err_o,
    output logic                          i_stall_o,
    input  logic [`XLEN-`XLEN_GRAN-1:0]   d_adr_i,
    input  logic [`XLEN-1:0]              d_dat_i,
    input  logic [`XLEN/8-1:0]            d_sel_i,
    input  logic                          d_we_i,
    input  logic                          d_cyc_i,
    input  logic                          d_stb_i,
    output logic [`XLEN-1:0]              d_dat_o,
    output logic                          d_ack_o,
    output logic                          d_err_o,
    output logic                          d_stall_o,
    output logic [`XLEN-`XLEN_GRAN-1:0]   adr_o,
    output logic [`XLEN-1:0]              dat_o,
    output logic [`XLEN/8-1:0]            sel_o,
    output logic                          we_o,
    output logic                          cyc_o,
    output logic                          stb_o,
    input  logic [`XLEN-1:0]              dat_i,
    input  logic                          ack_i,
    input  logic                          err_i,
    input  logic                          stall_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   rearb;
    logic   contend_pick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
`ifdef MR_BUSARB_RR_EN
        contend_pick_d = ~last_d_q;
`else
        contend_pick_d = 1'b1;
`endif
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            GNT_I:   rearb = ~i_cyc_i;
            GNT_D:   rearb = ~d_cyc_i;
            default: rearb = 1'b1;
        endcase
        // Release and new request on the same edge resolve here, so handoff costs no cycle.
        if (rearb) begin
            if (i_cyc_i && d_cyc_i) begin
                state_d = contend_pick_d ? GNT_D : GNT_I;
            end else if (i_cyc_i) begin
                state_d = GNT_I;
            end else if (d_cyc_i) begin
                state_d = GNT_D;
            end else begin
                state_d = IDLE;
            end
            if (state_d != IDLE) begin
                last_d_d = (state_d == GNT_D);
            end
        end
    end

    assign i_dat_o = dat_i;
    assign d_dat_o = dat_i;

    always_comb begin
        adr_o     = '0;
        dat_o     = '0;
        sel_o     = '0;
        we_o      = 1'b0;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        i_ack_o   = 1'b0;
        i_err_o   = 1'b0;
        i_stall_o = 1'b1;
        d_ack_o   = 1'b0;
        d_err_o   = 1'b0;
        d_stall_o = 1'b1;
        case (state_q)
            GNT_I: begin
                adr_o     = i_adr_i;
                sel_o     = '1;
                cyc_o     = i_cyc_i;
                stb_o     = i_stb_i;
                i_ack_o   = ack_i;
                i_err_o   = err_i;
                i_stall_o = stall_i;
            end
            GNT_D: begin
                adr_o     = d_adr_i;
                dat_o     = d_dat_i;
                sel_o     = d_sel_i;
                we_o      = d_we_i;
                cyc_o     = d_cyc_i;
                stb_o     = d_stb_i;
                d_ack_o   = ack_i;
                d_err_o   = err_i;
                d_stall_o = stall_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mr_busarb.sv
// Self-checking bench for mr_busarb: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an ownership model.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

module tb_mr_busarb;

    localparam int AW = `XLEN - `XLEN_GRAN;
    localparam int DW = `XLEN;
    localparam int SW = `XLEN / 8;
`ifdef MR_BUSARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst;
    logic [AW-1:0] i_adr_i, d_adr_i, adr_o;
    logic          i_cyc_i, i_stb_i, i_ack_o, i_err_o, i_stall_o;
    logic [DW-1:0] i_dat_o, d_dat_i, d_dat_o, dat_o, dat_i;
    logic [SW-1:0] d_sel_i, sel_o;
    logic          d_we_i, d_cyc_i, d_stb_i, d_ack_o, d_err_o, d_stall_o;
    logic          we_o, cyc_o, stb_o, ack_i, err_i, stall_i;

    int checks   = 0;
    int failures = 0;

    mr_busarb dut (
        .clk(clk), .rst(rst),
        .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
        .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_stall_o(i_stall_o),
        .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i), .d_we_i(d_we_i),
        .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
        .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_stall_o(d_stall_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 I, 2 D) and who was granted last.
    int owner  = 0;
    bit last_d = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner  = 0;
            last_d = 1'b1;
        end else if (!((owner == 1 && i_cyc_i) || (owner == 2 && d_cyc_i))) begin
            if (i_cyc_i && d_cyc_i) owner = (RR && last_d) ? 1 : 2;
            else if (i_cyc_i)       owner = 1;
            else if (d_cyc_i)       owner = 2;
            else                    owner = 0;
            if (owner != 0) last_d = (owner == 2);
        end
    end

    // Every-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [SW-1:0] ones;
        ones = '1;
        check("i_dat_bcast", 64'(i_dat_o), 64'(dat_i));
        check("d_dat_bcast", 64'(d_dat_o), 64'(dat_i));
        if (owner == 1) begin
            check("m_cyc", 64'(cyc_o), 64'(i_cyc_i));
            check("m_stb", 64'(stb_o), 64'(i_stb_i));
            check("m_we",  64'(we_o), 64'd0);
            check("m_adr", 64'(adr_o), 64'(i_adr_i));
            check("m_sel", 64'(sel_o), 64'(ones));
            check("m_dat", 64'(dat_o), 64'd0);
            check("m_iresp", 64'({i_ack_o, i_err_o, i_stall_o}), 64'({ack_i, err_i, stall_i}));
            check("m_dresp", 64'({d_ack_o, d_err_o, d_stall_o}), 64'd1);
        end else if (owner == 2) begin
            check("m_cyc", 64'(cyc_o), 64'(d_cyc_i));
            check("m_stb", 64'(stb_o), 64'(d_stb_i));
            check("m_we",  64'(we_o), 64'(d_we_i));
            check("m_adr", 64'(adr_o), 64'(d_adr_i));
            check("m_sel", 64'(sel_o), 64'(d_sel_i));
            check("m_dat", 64'(dat_o), 64'(d_dat_i));
            check("m_dresp", 64'({d_ack_o, d_err_o, d_stall_o}), 64'({ack_i, err_i, stall_i}));
            check("m_iresp", 64'({i_ack_o, i_err_o, i_stall_o}), 64'd1);
        end else begin
            check("m_idle_ctl", 64'({cyc_o, stb_o, we_o}), 64'd0);
            check("m_iresp", 64'({i_ack_o, i_err_o, i_stall_o}), 64'd1);
            check("m_dresp", 64'({d_ack_o, d_err_o, d_stall_o}), 64'd1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        i_adr_i = '0; i_cyc_i = 0; i_stb_i = 0;
        d_adr_i = '0; d_dat_i = '0; d_sel_i = '0; d_we_i = 0; d_cyc_i = 0; d_stb_i = 0;
        dat_i = '0; ack_i = 0; err_i = 0; stall_i = 0;
    endtask

    task automatic do_reset;
        tick; rst = 1'b1;
        tick; rst = 1'b0;
    endtask

    initial begin
        logic [SW-1:0] ones;
        logic          exp_d;
        ones = '1;
        rst = 1'b1;
        clear_inputs;
        #2;
        check("rst_cyc", 64'(cyc_o), 64'd0);
        check("rst_stalls", 64'({i_stall_o, d_stall_o}), 64'd3);
        check("rst_acks", 64'({i_ack_o, i_err_o, d_ack_o, d_err_o}), 64'd0);
        tick; tick; rst = 1'b0;

        // Single I transfer
        tick; i_cyc_i = 1; i_stb_i = 1; i_adr_i = AW'('h40);
        #2 check("i_lat_idle", 64'(cyc_o), 64'd0);
        tick; #2;
        check("i_cyc", 64'(cyc_o), 64'd1);
        check("i_adr", 64'(adr_o), 64'h40);
        check("i_we",  64'(we_o), 64'd0);
        check("i_sel", 64'(sel_o), 64'(ones));
        tick; i_stb_i = 0;
        tick; ack_i = 1; dat_i = DW'('h13);
        #2;
        check("i_ack", 64'(i_ack_o), 64'd1);
        check("i_dat", 64'(i_dat_o), 64'h13);
        check("i_dack", 64'(d_ack_o), 64'd0);
        tick; ack_i = 0; i_cyc_i = 0;
        tick; #2 check("i_done", 64'(cyc_o), 64'd0);

        // Contention twice from IDLE, then handoff from D to I
        do_reset;
        tick; i_cyc_i = 1; i_stb_i = 1; i_adr_i = AW'('h44);
        d_cyc_i = 1; d_stb_i = 1; d_adr_i = AW'('h80);
        exp_d = !RR;
        tick; #2;
        check("cont1_adr", 64'(adr_o), exp_d ? 64'h80 : 64'h44);
        check("cont1_istall", 64'(i_stall_o), exp_d ? 64'd1 : 64'd0);
        tick; i_cyc_i = 0; d_cyc_i = 0;
        tick; i_cyc_i = 1; d_cyc_i = 1;
        tick; #2;
        check("cont2_adr", 64'(adr_o), 64'h80);
        check("cont2_istall", 64'(i_stall_o), 64'd1);
        tick; #2 check("hold_istall", 64'(i_stall_o), 64'd1);
        d_cyc_i = 0;
        #1 check("rel_cyc", 64'(cyc_o), 64'd0);
        tick; #2;
        check("hand_adr", 64'(adr_o), 64'h44);
        check("hand_cyc", 64'(cyc_o), 64'd1);
        check("hand_istall", 64'(i_stall_o), 64'd0);
        tick; clear_inputs;

        // D write with slave stall
        tick; d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_sel_i = SW'('b0011);
        d_dat_i = DW'('hDEADBEEF); d_adr_i = AW'('h10);
        tick; stall_i = 1;
        #2;
        check("dw_dat", 64'(dat_o), 64'hDEADBEEF);
        check("dw_sel", 64'(sel_o), 64'h3);
        check("dw_we",  64'(we_o), 64'd1);
        check("dw_stall", 64'({i_stall_o, d_stall_o}), 64'd3);
        tick; #2 check("dw_stall2", 64'(d_stall_o), 64'd1);
        stall_i = 0;
        #1 check("dw_unstall", 64'({i_stall_o, d_stall_o}), 64'd2);
        tick; clear_inputs;

        // Error during I grant keeps the grant
        tick; i_cyc_i = 1; i_stb_i = 1; i_adr_i = AW'('h20); d_adr_i = AW'('h30);
        tick; err_i = 1; d_cyc_i = 1;
        #2 check("err_route", 64'({i_err_o, d_err_o}), 64'd2);
        tick; err_i = 0;
        #2 check("err_hold", 64'(adr_o), 64'h20);
        tick; i_cyc_i = 0;
        tick; #2 check("err_next", 64'(adr_o), 64'h30);
        tick; clear_inputs;

        // Async reset mid D grant
        tick; d_cyc_i = 1; d_stb_i = 1;
        tick; #2 check("ar_pre", 64'(cyc_o), 64'd1);
        rst = 1'b1;
        #1;
        check("ar_ctl", 64'({cyc_o, stb_o}), 64'd0);
        check("ar_stalls", 64'({i_stall_o, d_stall_o}), 64'd3);
        tick; rst = 1'b0; i_cyc_i = 1; i_stb_i = 1;
        i_adr_i = AW'('h4); d_adr_i = AW'('h8);
        tick; #2 check("ar_first", 64'(adr_o), RR ? 64'h4 : 64'h8);
        tick; clear_inputs;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) i_cyc_i = ~i_cyc_i;
            if ($urandom_range(0, 3) == 0) d_cyc_i = ~d_cyc_i;
            i_stb_i = 1'($urandom);
            d_stb_i = 1'($urandom);
            d_we_i  = 1'($urandom);
            i_adr_i = AW'($urandom);
            d_adr_i = AW'($urandom);
            d_dat_i = DW'($urandom);
            d_sel_i = SW'($urandom);
            dat_i   = DW'($urandom);
            ack_i   = 1'($urandom);
            err_i   = ($urandom_range(0, 7) == 0);
            stall_i = 1'($urandom);
        end
        tick; rst = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
